// File: rtl/ram8_seq_pkg.sv
// Shared constants and types for the RAM8 sequencer and its RAM8 target.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ram8_seq_pkg;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int DW    = 16;

    // Largest legal word count for one command.
    localparam logic [3:0] LEN_MAX = 4'(DEPTH);

    localparam logic [1:0] OP_FILL = 2'b00;
    localparam logic [1:0] OP_COPY = 2'b01;
    localparam logic [1:0] OP_SUM  = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FILL    = 3'd1,
        ST_COPY_RD = 3'd2,
        ST_COPY_WR = 3'd3,
        ST_SUM     = 3'd4
    } state_t;

    // Address arithmetic wraps naturally in AW bits.
    function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] base,
                                               input logic [AW-1:0] idx);
        return base + idx;
    endfunction

endpackage

// File: rtl/ram8.sv
// 8x16 RAM with combinational read and write landing on the rising edge.
// Latency: read 0 cycles, write visible the cycle after write=1.
// Backpressure: none, accepts one access per cycle.
module ram8
    import ram8_seq_pkg::*;
(
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] in,
    input  logic          write,
    output logic [DW-1:0] out
);

    logic [DW-1:0] mem_q [DEPTH];

    // Storage array: write lands on the edge that ends the write cycle.
    always_ff @(posedge clk) begin
        if (write) begin
            mem_q[addr] <= in;
        end
    end

    assign out = mem_q[addr];

endmodule

// File: rtl/ram8_sequencer.sv
// Block FILL/COPY/SUM initiator driving one RAM8 over a wrapping address range.
// Latency: FILL/SUM len cycles, COPY 2*len cycles, done one cycle after the last work cycle.
// Backpressure: one command at a time; start is ignored while busy, nothing is queued.
module ram8_sequencer
    import ram8_seq_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [3:0]    len,
    input  logic [DW-1:0] data,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_in,
    output logic          mem_write,
    input  logic [DW-1:0] mem_out,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [DW-1:0] result
);

    state_t        state_q,  state_d;
    logic [AW-1:0] i_q,      i_d;
    logic [AW-1:0] src_q,    src_d;
    logic [AW-1:0] dst_q,    dst_d;
    logic [3:0]    len_q,    len_d;
    logic [DW-1:0] data_q,   data_d;
    logic [DW-1:0] buf_q,    buf_d;
    logic [DW-1:0] result_q, result_d;
    logic          err_q,    err_d;
    logic          done_q,   done_d;

    logic          last_word;
    logic          cmd_illegal;

    assign last_word   = ({1'b0, i_q} == (len_q - 4'd1));
    assign cmd_illegal = (op == OP_RSVD) || (len > LEN_MAX);

    // State and datapath registers; async reset aborts any command without a done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            i_q      <= '0;
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            data_q   <= '0;
            buf_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            len_q    <= len_d;
            data_q   <= data_d;
            buf_q    <= buf_d;
            result_q <= result_d;
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end

    // Next-state: command accept in IDLE, per-word stepping in the work states.
    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        src_d    = src_q;
        dst_d    = dst_q;
        len_d    = len_q;
        data_d   = data_q;
        buf_d    = buf_q;
        result_d = result_q;
        err_d    = err_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    src_d  = src;
                    dst_d  = dst;
                    len_d  = len;
                    data_d = data;
                    i_d    = '0;
                    err_d  = 1'b0;
                    if (cmd_illegal) begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        if (op == OP_SUM) begin
                            result_d = '0;
                        end
                        if (len == 4'd0) begin
                            done_d = 1'b1;
                        end else begin
                            case (op)
                                OP_FILL: state_d = ST_FILL;
                                OP_COPY: state_d = ST_COPY_RD;
                                default: state_d = ST_SUM;
                            endcase
                        end
                    end
                end
            end
            ST_FILL: begin
                if (last_word) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            ST_COPY_RD: begin
                buf_d   = mem_out;
                state_d = ST_COPY_WR;
            end
            ST_COPY_WR: begin
                if (last_word) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    i_d     = i_q + 1'b1;
                    state_d = ST_COPY_RD;
                end
            end
            ST_SUM: begin
                result_d = result_q + mem_out;
                if (last_word) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Moore memory-port decode: stable for the whole cycle, quiet in IDLE.
    always_comb begin
        mem_addr  = '0;
        mem_in    = '0;
        mem_write = 1'b0;
        case (state_q)
            ST_FILL: begin
                mem_addr  = wrap_add(dst_q, i_q);
                mem_in    = data_q;
                mem_write = 1'b1;
            end
            ST_COPY_RD: begin
                mem_addr = wrap_add(src_q, i_q);
            end
            ST_COPY_WR: begin
                mem_addr  = wrap_add(dst_q, i_q);
                mem_in    = buf_q;
                mem_write = 1'b1;
            end
            ST_SUM: begin
                mem_addr = wrap_add(src_q, i_q);
            end
            default: begin
                mem_addr  = '0;
            end
        endcase
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = done_q;
    assign err    = err_q;
    assign result = result_q;

endmodule

// File: tb/tb_ram8_sequencer.sv
// Directed bench: sequencer driving a real RAM8, checked with immediate assertions.
// Latency: checks done offsets relative to the accept edge.
// Backpressure: exercises start filtering while busy and back-to-back starts.
module tb_ram8_sequencer;
    import ram8_seq_pkg::*;

    logic          clk;
    logic          reset;
    logic          start;
    logic [1:0]    op;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [3:0]    len;
    logic [DW-1:0] data;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_in;
    logic          mem_write;
    logic [DW-1:0] mem_out;
    logic          busy;
    logic          done;
    logic          err;
    logic [DW-1:0] result;

    int total = 0;
    int bad   = 0;
    int wr_cnt = 0;
    logic [AW-1:0] wr_log [$];

    ram8_sequencer u_dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .src(src), .dst(dst),
        .len(len), .data(data), .mem_addr(mem_addr), .mem_in(mem_in),
        .mem_write(mem_write), .mem_out(mem_out), .busy(busy), .done(done),
        .err(err), .result(result)
    );

    ram8 u_ram (
        .clk(clk), .addr(mem_addr), .in(mem_in), .write(mem_write), .out(mem_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Log every write cycle mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (mem_write === 1'b1) begin
            wr_cnt++;
            wr_log.push_back(mem_addr);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Drive one command; returns in cycle T+1 after the accept edge T.
    task automatic issue(input logic [1:0] o, input logic [2:0] s, input logic [2:0] d,
                         input logic [3:0] l, input logic [15:0] v);
        op = o; src = s; dst = d; len = l; data = v;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Waits for done; cyc is the cycle offset from the accept edge, bc the busy cycles seen.
    task automatic wait_done(output int cyc, output int bc);
        int n;
        n  = 1;
        bc = 0;
        while (done !== 1'b1 && n < 40) begin
            if (busy === 1'b1) bc++;
            @(posedge clk); #1;
            n++;
        end
        if (done !== 1'b1) check("done_timeout", {31'd0, done}, 32'd1);
        cyc = n;
    endtask

    task automatic run_cmd(input logic [1:0] o, input logic [2:0] s, input logic [2:0] d,
                           input logic [3:0] l, input logic [15:0] v,
                           output int cyc, output int bc);
        issue(o, s, d, l, v);
        wait_done(cyc, bc);
    endtask

    // mem[k] = k+1 via single-word fills.
    task automatic preload_inc();
        int c, b;
        for (int k = 0; k < 8; k++) run_cmd(OP_FILL, 3'd0, 3'(k), 4'd1, 16'(k + 1), c, b);
    endtask

    initial begin
        int cyc, bc, w0;
        reset = 1'b1; start = 1'b0; op = '0; src = '0; dst = '0; len = '0; data = '0;

        // Reset state
        #3;
        check("rst_mem_addr",  {29'd0, mem_addr}, 32'd0);
        check("rst_mem_in",    {16'd0, mem_in}, 32'd0);
        check("rst_mem_write", {31'd0, mem_write}, 32'd0);
        check("rst_busy",      {31'd0, busy}, 32'd0);
        check("rst_done",      {31'd0, done}, 32'd0);
        check("rst_err",       {31'd0, err}, 32'd0);
        check("rst_result",    {16'd0, result}, 32'd0);
        #9 reset = 1'b0;
        @(posedge clk); #1;

        // FILL with wrap: dst=6 len=4 -> 6,7,0,1
        run_cmd(OP_FILL, 3'd0, 3'd0, 4'd8, 16'h0000, cyc, bc);
        check("zero_fill_done", cyc, 9);
        wr_log.delete();
        issue(OP_FILL, 3'd0, 3'd6, 4'd4, 16'hA5A5);
        check("fill_first_addr", {29'd0, mem_addr}, 32'd6);
        check("fill_first_in", {16'd0, mem_in}, 32'hA5A5);
        wait_done(cyc, bc);
        check("fill_done_cyc", cyc, 5);
        check("fill_busy_cyc", bc, 4);
        check("fill_done_busy", {31'd0, busy}, 32'd0);
        check("fill_nwr", wr_log.size(), 4);
        if (wr_log.size() == 4) begin
            check("fill_wa0", {29'd0, wr_log[0]}, 32'd6);
            check("fill_wa1", {29'd0, wr_log[1]}, 32'd7);
            check("fill_wa2", {29'd0, wr_log[2]}, 32'd0);
            check("fill_wa3", {29'd0, wr_log[3]}, 32'd1);
        end
        check("fill_m6", {16'd0, u_ram.mem_q[6]}, 32'hA5A5);
        check("fill_m7", {16'd0, u_ram.mem_q[7]}, 32'hA5A5);
        check("fill_m0", {16'd0, u_ram.mem_q[0]}, 32'hA5A5);
        check("fill_m1", {16'd0, u_ram.mem_q[1]}, 32'hA5A5);
        for (int k = 2; k < 6; k++) check("fill_untouched", {16'd0, u_ram.mem_q[k]}, 32'd0);

        // COPY non-overlapping: src=0 dst=4 len=3
        preload_inc();
        run_cmd(OP_COPY, 3'd0, 3'd4, 4'd3, 16'h0, cyc, bc);
        check("copy_done_cyc", cyc, 7);
        check("copy_busy_cyc", bc, 6);
        check("copy_m4", {16'd0, u_ram.mem_q[4]}, 32'd1);
        check("copy_m5", {16'd0, u_ram.mem_q[5]}, 32'd2);
        check("copy_m6", {16'd0, u_ram.mem_q[6]}, 32'd3);
        check("copy_m7", {16'd0, u_ram.mem_q[7]}, 32'd8);
        check("copy_m3", {16'd0, u_ram.mem_q[3]}, 32'd4);

        // COPY overlapping, forward semantics: src=0 dst=1 len=3
        preload_inc();
        run_cmd(OP_COPY, 3'd0, 3'd1, 4'd3, 16'h0, cyc, bc);
        check("ovl_m1", {16'd0, u_ram.mem_q[1]}, 32'd1);
        check("ovl_m2", {16'd0, u_ram.mem_q[2]}, 32'd1);
        check("ovl_m3", {16'd0, u_ram.mem_q[3]}, 32'd1);
        check("ovl_m4", {16'd0, u_ram.mem_q[4]}, 32'd5);

        // SUM with wrap: mem={FFFF,2,3,0,...}, src=7 len=4
        run_cmd(OP_FILL, 3'd0, 3'd0, 4'd8, 16'h0000, cyc, bc);
        run_cmd(OP_FILL, 3'd0, 3'd0, 4'd1, 16'hFFFF, cyc, bc);
        run_cmd(OP_FILL, 3'd0, 3'd1, 4'd1, 16'h0002, cyc, bc);
        run_cmd(OP_FILL, 3'd0, 3'd2, 4'd1, 16'h0003, cyc, bc);
        w0 = wr_cnt;
        issue(OP_SUM, 3'd7, 3'd0, 4'd4, 16'h0);
        check("sum_cleared", {16'd0, result}, 32'd0);
        check("sum_first_addr", {29'd0, mem_addr}, 32'd7);
        wait_done(cyc, bc);
        check("sum_done_cyc", cyc, 5);
        check("sum_result", {16'd0, result}, 32'h0004);
        check("sum_no_write", wr_cnt - w0, 0);

        // COPY len=0: immediate done, result held
        run_cmd(OP_COPY, 3'd0, 3'd0, 4'd0, 16'h0, cyc, bc);
        check("len0_done_cyc", cyc, 1);
        check("len0_err", {31'd0, err}, 32'd0);
        check("len0_result", {16'd0, result}, 32'h0004);
        check("len0_no_write", wr_cnt - w0, 0);

        // Illegal commands
        run_cmd(OP_RSVD, 3'd0, 3'd0, 4'd2, 16'h1111, cyc, bc);
        check("rsvd_done_cyc", cyc, 1);
        check("rsvd_err", {31'd0, err}, 32'd1);
        check("rsvd_busy", {31'd0, busy}, 32'd0);
        run_cmd(OP_FILL, 3'd0, 3'd0, 4'd9, 16'h2222, cyc, bc);
        check("len9_done_cyc", cyc, 1);
        check("len9_err", {31'd0, err}, 32'd1);
        check("illegal_no_write", wr_cnt - w0, 0);
        run_cmd(OP_FILL, 3'd0, 3'd3, 4'd1, 16'h0055, cyc, bc);
        check("legal_clears_err", {31'd0, err}, 32'd0);
        check("legal_fill_done_cyc", cyc, 2);

        // Reset mid-FILL plus start filtering while busy
        run_cmd(OP_FILL, 3'd0, 3'd0, 4'd8, 16'h0000, cyc, bc);
        issue(OP_FILL, 3'd0, 3'd0, 4'd8, 16'h1234);
        dst = 3'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_start_ignored_addr", {29'd0, mem_addr}, 32'd1);
        check("busy_start_ignored_wr", {31'd0, mem_write}, 32'd1);
        @(posedge clk); #1;
        check("third_cycle_wr", {31'd0, mem_write}, 32'd1);
        #1 reset = 1'b1;
        #1;
        check("rst_mid_wr", {31'd0, mem_write}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        #3 reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("rst_no_done", {31'd0, done}, 32'd0);
        end
        check("rst_m0", {16'd0, u_ram.mem_q[0]}, 32'h1234);
        check("rst_m1", {16'd0, u_ram.mem_q[1]}, 32'h1234);
        for (int k = 2; k < 8; k++) check("rst_m_untouched", {16'd0, u_ram.mem_q[k]}, 32'd0);

        // start in the done cycle is accepted
        run_cmd(OP_FILL, 3'd0, 3'd4, 4'd1, 16'h0007, cyc, bc);
        issue(OP_FILL, 3'd0, 3'd5, 4'd1, 16'h0008);
        check("b2b_busy", {31'd0, busy}, 32'd1);
        check("b2b_addr", {29'd0, mem_addr}, 32'd5);
        wait_done(cyc, bc);
        check("b2b_done_cyc", cyc, 2);
        check("b2b_m4", {16'd0, u_ram.mem_q[4]}, 32'd7);
        check("b2b_m5", {16'd0, u_ram.mem_q[5]}, 32'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
